// File: rtl/result_serializer_pkg.sv
// Shared types and sizing helpers for the result serializer output stage.
package result_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int bytes_for(input int acc_width);
    return (acc_width + 7) / 8;
  endfunction

  // Bytes emitted per vector: one per slice when saturating, full width otherwise.
  function automatic int byte_count(input int slices, input int nbytes, input logic sat_mode);
    return sat_mode ? slices : slices * nbytes;
  endfunction

endpackage

// File: rtl/acc_saturate.sv
// Clamps a signed accumulator into the int8 range [-128, 127].
module acc_saturate #(
  parameter int ACC_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  output logic [7:0]           o_sat
);

  localparam logic signed [ACC_WIDTH-1:0] MAX8 = ACC_WIDTH'(127);
  localparam logic signed [ACC_WIDTH-1:0] MIN8 = ACC_WIDTH'(-128);

  logic signed [ACC_WIDTH-1:0] w_acc;
  assign w_acc = $signed(i_acc);

  always_comb begin
    if (w_acc > MAX8)      o_sat = 8'h7F;
    else if (w_acc < MIN8) o_sat = 8'h80;
    else                   o_sat = i_acc[7:0];
  end

endmodule

// File: rtl/result_serializer.sv
// Captures a vector of signed accumulators and streams it out a byte per advance,
// with a one-entry shadow so the next vector can be handed over while draining.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int COMPUTE_SLICES = 4,
  parameter int ACC_WIDTH      = 16
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_load,
  input  logic [COMPUTE_SLICES*ACC_WIDTH-1:0] i_acc_in,
  input  logic                                i_sat8,
  output logic                                o_load_ready,
  input  logic                                i_advance,
  output logic [7:0]                          o_data_out,
  output logic                                o_data_valid,
  output logic                                o_last,
  output logic                                o_overflow
);

  localparam int BYTES = bytes_for(ACC_WIDTH);
  localparam int EXT_W = BYTES * 8;
  localparam int VEC_W = COMPUTE_SLICES * ACC_WIDTH;
  localparam int IDX_W = $clog2(COMPUTE_SLICES * BYTES + 1);

  localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(byte_count(COMPUTE_SLICES, BYTES, 1'b0) - 1);
  localparam logic [IDX_W-1:0] LAST_SAT  = IDX_W'(byte_count(COMPUTE_SLICES, BYTES, 1'b1) - 1);
  localparam logic [IDX_W-1:0] BYTES_I   = IDX_W'(BYTES);

  state_t             r_state;
  logic [VEC_W-1:0]   r_out_vec;
  logic               r_out_mode;
  logic [IDX_W-1:0]   r_idx;
  logic [VEC_W-1:0]   r_sh_vec;
  logic               r_sh_mode;
  logic               r_sh_full;
  logic               r_overflow;

  logic [IDX_W-1:0]     w_sel;
  logic [IDX_W-1:0]     w_bsel;
  logic [IDX_W-1:0]     w_last_idx;
  logic [ACC_WIDTH-1:0] w_slice;
  logic [EXT_W-1:0]     w_ext;
  logic [7:0]           w_full_byte;
  logic [7:0]           w_sat;
  logic                 w_valid;
  logic                 w_at_last;
  logic                 w_load_ok;
  logic                 w_pop;

  // Flat byte index maps to a slice and a byte within the sign-extended slice.
  assign w_sel      = r_out_mode ? r_idx : r_idx / BYTES_I;
  assign w_bsel     = r_out_mode ? '0    : r_idx % BYTES_I;
  assign w_last_idx = r_out_mode ? LAST_SAT : LAST_FULL;

  always_comb begin
    w_slice = '0;
    for (int s = 0; s < COMPUTE_SLICES; s++) begin
      if (w_sel == IDX_W'(s)) w_slice = r_out_vec[s*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  assign w_ext = EXT_W'($signed(w_slice));

  always_comb begin
    w_full_byte = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (w_bsel == IDX_W'(b)) w_full_byte = w_ext[b*8 +: 8];
    end
  end

  acc_saturate #(.ACC_WIDTH(ACC_WIDTH)) u_acc_saturate (
    .i_acc (w_slice),
    .o_sat (w_sat)
  );

  assign w_valid   = (r_state == SHIFT);
  assign w_at_last = (r_idx == w_last_idx);
  assign w_load_ok = i_load && !r_sh_full;
  assign w_pop     = i_advance && w_valid;

  assign o_load_ready = !r_sh_full;
  assign o_data_valid = w_valid;
  assign o_data_out   = w_valid ? (r_out_mode ? w_sat : w_full_byte) : 8'h00;
  assign o_last       = w_valid && w_at_last;
  assign o_overflow   = r_overflow;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_out_vec  <= '0;
      r_out_mode <= 1'b0;
      r_idx      <= '0;
      r_sh_vec   <= '0;
      r_sh_mode  <= 1'b0;
      r_sh_full  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (i_load && r_sh_full) r_overflow <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_load_ok) begin
            r_out_vec  <= i_acc_in;
            r_out_mode <= i_sat8;
            r_idx      <= '0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_pop && !w_at_last) begin
            r_idx <= r_idx + 1'b1;
          end else if (w_pop) begin
            // Final byte popped: refill from shadow first, else take a same-edge load.
            if (r_sh_full) begin
              r_out_vec  <= r_sh_vec;
              r_out_mode <= r_sh_mode;
              r_idx      <= '0;
              r_sh_full  <= 1'b0;
            end else if (w_load_ok) begin
              r_out_vec  <= i_acc_in;
              r_out_mode <= i_sat8;
              r_idx      <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
          if (w_load_ok && !(w_pop && w_at_last)) begin
            r_sh_vec  <= i_acc_in;
            r_sh_mode <= i_sat8;
            r_sh_full <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer with a byte-list reference model.
module tb_result_serializer;

  localparam int S = 2;
  localparam int W = 12;
  localparam int B = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           load;
  logic [S*W-1:0] acc;
  logic           sat8;
  logic           adv;
  logic           load_ready;
  logic [7:0]     data_out;
  logic           data_valid;
  logic           last;
  logic           overflow;

  result_serializer #(.COMPUTE_SLICES(S), .ACC_WIDTH(W)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_load       (load),
    .i_acc_in     (acc),
    .i_sat8       (sat8),
    .o_load_ready (load_ready),
    .i_advance    (adv),
    .o_data_out   (data_out),
    .o_data_valid (data_valid),
    .o_last       (last),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  int         lens[$];
  logic [7:0] seen_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       ov_model = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int sval(input logic [W-1:0] v);
    return (v >= 12'd2048) ? int'(v) - 4096 : int'(v);
  endfunction

  // Expected byte stream for one vector, derived arithmetically from slice values.
  task automatic push_vector(input logic [S*W-1:0] a, input logic m);
    int   sv, c, n;
    exp_t e;
    n = 0;
    for (int s = 0; s < S; s++) begin
      sv = sval(a[s*W +: W]);
      if (m) begin
        c = (sv > 127) ? 127 : ((sv < -128) ? -128 : sv);
        e.data = 8'(c & 255);
        e.last = (s == S-1);
        exp_q.push_back(e);
        n++;
      end else begin
        for (int b = 0; b < B; b++) begin
          e.data = 8'((sv >>> (8*b)) & 255);
          e.last = (s == S-1) && (b == B-1);
          exp_q.push_back(e);
          n++;
        end
      end
    end
    lens.push_back(n);
  endtask

  // One clock: check control outputs against the model, drive inputs, advance the model.
  task automatic cycle(input logic l, input logic [S*W-1:0] a, input logic m, input logic adv_i);
    bit ready;
    check("load_ready", int'(load_ready), int'(lens.size() < 2));
    check("overflow",   int'(overflow),   int'(ov_model));
    check("data_valid", int'(data_valid), int'(lens.size() > 0));
    load = l; acc = a; sat8 = m; adv = adv_i;
    ready = (lens.size() < 2);
    if (adv_i && lens.size() > 0) begin
      lens[0] = lens[0] - 1;
      if (lens[0] == 0) void'(lens.pop_front());
    end
    if (l) begin
      if (ready) push_vector(a, m);
      else       ov_model = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic adv_i);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, adv_i);
  endtask

  task automatic check_seen(input string name, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input int cnt);
    logic [7:0] ev[4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    check({name, "_count"}, seen_q.size(), cnt);
    for (int i = 0; i < cnt && i < seen_q.size(); i++) check(name, int'(seen_q[i]), int'(ev[i]));
    seen_q.delete();
  endtask

  // Monitor: compares the presented byte against the scoreboard head; pops on advance.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 1, 0);
        end else begin
          check("data_out", int'(data_out), int'(exp_q[0].data));
          check("last",     int'(last),     int'(exp_q[0].last));
          if (adv) begin
            seen_q.push_back(data_out);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("idle_data_out", int'(data_out), 0);
        check("idle_last",     int'(last),     0);
      end
    end
  end

  function automatic logic [W-1:0] rand_slice();
    logic [W-1:0] pick[6];
    pick[0] = 12'h7FF; pick[1] = 12'h800; pick[2] = 12'h07F;
    pick[3] = 12'h080; pick[4] = 12'hF80; pick[5] = 12'hF7F;
    if ($urandom_range(0, 2) == 0) return pick[$urandom_range(0, 5)];
    return W'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; acc = '0; sat8 = 1'b0; adv = 1'b0;
    #3;
    check("rst_valid",  int'(data_valid), 0);
    check("rst_data",   int'(data_out),   0);
    check("rst_last",   int'(last),       0);
    check("rst_ready",  int'(load_ready), 1);
    check("rst_ovf",    int'(overflow),   0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Full mode, advance held high
    seen_q.delete();
    cycle(1'b1, {12'hF00, 12'h123}, 1'b0, 1'b1);
    idle(5, 1'b1);
    check_seen("full_bytes", 8'h23, 8'h01, 8'h00, 8'hFF, 4);

    // sat8 mode
    cycle(1'b1, {12'hF00, 12'h123}, 1'b1, 1'b1);
    idle(3, 1'b1);
    check_seen("sat_bytes", 8'h7F, 8'h80, 8'h00, 8'h00, 2);
    cycle(1'b1, {12'hFFB, 12'h005}, 1'b1, 1'b1);
    idle(3, 1'b1);
    check_seen("sat_small", 8'h05, 8'hFB, 8'h00, 8'h00, 2);

    // Back-to-back A then B: gap-free, load_ready drops after B
    cycle(1'b1, {12'h456, 12'h789}, 1'b0, 1'b1);
    cycle(1'b1, {12'hABC, 12'h0DE}, 1'b0, 1'b1);
    check("b2b_ready_low", int'(load_ready), 0);
    idle(9, 1'b1);

    // Overflow: third load while shadow full is dropped
    cycle(1'b1, {12'h111, 12'h222}, 1'b0, 1'b1);
    cycle(1'b1, {12'h333, 12'h444}, 1'b0, 1'b1);
    cycle(1'b1, {12'h555, 12'h666}, 1'b0, 1'b1);
    check("ovf_set", int'(overflow), 1);
    idle(9, 1'b1);
    check("ovf_sticky", int'(overflow), 1);
    seen_q.delete();

    // Stall on byte 2
    cycle(1'b1, {12'hF00, 12'h123}, 1'b0, 1'b0);
    idle(2, 1'b1);
    idle(5, 1'b0);
    idle(3, 1'b1);
    check_seen("stall_bytes", 8'h23, 8'h01, 8'h00, 8'hFF, 4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 3), {rand_slice(), rand_slice()},
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 20 && lens.size() > 0; i++) idle(1, 1'b1);
    idle(1, 1'b0);
    check("drain_empty", exp_q.size(), 0);

    // Reset mid-stream between edges
    cycle(1'b1, {12'h0AA, 12'h055}, 1'b0, 1'b0);
    cycle(1'b1, {12'h0BB, 12'h066}, 1'b0, 1'b1);
    load = 1'b0; adv = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(data_valid), 0);
    check("mid_rst_data",  int'(data_out),   0);
    check("mid_rst_last",  int'(last),       0);
    check("mid_rst_ready", int'(load_ready), 1);
    check("mid_rst_ovf",   int'(overflow),   0);
    exp_q.delete(); lens.delete(); seen_q.delete(); ov_model = 1'b0;
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, {12'h7FF, 12'h800}, 1'b0, 1'b1);
    idle(5, 1'b1);
    check_seen("post_rst", 8'h00, 8'hF8, 8'hFF, 8'h07, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
# result_serializer

Output stage of the 1.58-bit matrix multiplier, directly downstream of the compute slices. Captures one vector of signed per-slice accumulators and streams it out one byte per consumer strobe on the 8-bit output pins. A one-entry shadow buffer lets the compute slices hand over the next result while the current one is still draining. The block also supports an optional int8 saturation mode.

## Interface
- COMPUTE_SLICES, 4, number of accumulators per result vector (1..16)
- ACC_WIDTH, 16, signed accumulator width (9..24); BYTES = ceil(ACC_WIDTH/8)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- load  in  1  result strobe from compute slices
- acc_in  in  COMPUTE_SLICES*ACC_WIDTH  accumulators, slice 0 in LSBs, two's complement
- sat8  in  1  mode, sampled with load: 1 = one saturated int8 per slice, 0 = full width
- load_ready  out  1  high when a load will be accepted
- advance  in  1  consumer pops current byte (effective only while data_valid)
- data_out  out  8  current byte; 0 when data_valid low
- data_valid  out  1  data_out holds a valid byte
- last  out  1  data_out is final byte of the vector (only with data_valid)
- overflow  out  1  sticky: a load arrived while load_ready low

## Operation
- Storage: output register (vector, mode, byte index) plus shadow register (vector, mode, shadow_full flag).
- States: IDLE (output register empty), SHIFT (emitting bytes).
- load_ready = !shadow_full.
- load && load_ready in IDLE: the vector goes directly to the output register. The state becomes SHIFT and the index is 0.
- load && load_ready in SHIFT: the vector goes to the shadow and shadow_full is set.
- load && !load_ready: the vector is dropped, overflow is set, and existing data is unaffected.
- Byte count N: COMPUTE_SLICES*BYTES when mode = 0; COMPUTE_SLICES when mode = 1.
- Byte order: slice 0 first, then ascending slices.
  - Full mode: each slice is sign-extended to BYTES*8 bits and emitted little-endian.
  - sat8 mode: each slice is clamped to [-128, 127] and one byte is emitted.
- advance && data_valid, index < N-1: index increments.
- advance && data_valid, index = N-1 (last):
  - If shadow_full: the shadow moves to the output register on the same edge, the index is 0, shadow_full clears, and there is no bubble.
  - Otherwise: the state goes to IDLE.
- Simultaneous last-pop and load with shadow empty: the load is written into the output register as the new vector, with no bubble and nothing dropped.
- Simultaneous last-pop and load with shadow_full: load_ready is already low, so the load is dropped with overflow. The shadow transfers.
- advance while !data_valid is ignored.
- data_valid = (state == SHIFT).
- Reset values: IDLE, shadow_full = 0, load_ready = 1, data_valid = 0, data_out = 0, last = 0, overflow = 0. Reset mid-stream discards both buffers.

## Timing
- Load-to-data latency: a load sampled at edge E in IDLE gives data_valid = 1 and byte 0 after E.
- data_out, data_valid and last are combinational from the registered state and index. There is no combinational path from load or advance to any output.
- Throughput: one byte per cycle with advance held high. Consecutive vectors stream gap-free when the shadow is filled before the last pop.
- load_ready falls the cycle after a load into the shadow. It rises the cycle after the shadow transfer.

## Structure
- Shared package: state enum {IDLE, SHIFT}; function bytes_for(ACC_WIDTH); byte-count function of (COMPUTE_SLICES, mode).
- Sub-module acc_saturate: combinational signed ACC_WIDTH to int8 clamp. Instanced once on the currently selected slice.
- The byte mux (slice select, then byte select with sign extension) is inline in result_serializer.

## Test plan
Test parameters: COMPUTE_SLICES = 2, ACC_WIDTH = 12, BYTES = 2.
- Full mode, slices {0x123, 0xF00}, advance held high -> bytes 23, 01, 00, FF on 4 consecutive cycles; last only on FF; then data_valid = 0.
- sat8 mode, same vector -> bytes 7F, 80; last on 80. Also slices {5, 0xFFB} -> 05, FB.
- Back-to-back: load A, then load B one cycle later -> load_ready low after B. All 4 bytes of A are followed immediately by all 4 bytes of B with no idle cycle.
- Overflow: load A, load B, load C while draining -> C dropped; overflow = 1 and stays 1. The stream is A then B only.
- Stall: advance low for 5 cycles on byte 2 -> data_out holds 00 and data_valid stays 1. The stream resumes intact.
- Reset asserted mid-stream (async, between edges) -> all outputs 0 and load_ready = 1 immediately. The next load emits from byte 0.
